// File: rtl/operand_fetch_pkg.sv
// ----------------------------------------------------------------------------
// operand_fetch_pkg
// Shared widths and helpers for the register file and the pipeline stages.
//   REG_AW   : register-address width
//   DATA_W   : register data width
//   ZERO_REG : index of the hard-wired zero register
//   stage_fwd_t : one downstream stage's bypass tuple (valid, gr_we, dest, result)
//   stage_hit() : true when a stage will write the given source register
// ----------------------------------------------------------------------------
package operand_fetch_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              valid;
    logic              gr_we;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] result;
  } stage_fwd_t;

  // The zero register is never a bypass target, whatever the stage claims.
  function automatic logic stage_hit(input stage_fwd_t s, input logic [REG_AW-1:0] src);
    return s.valid && s.gr_we && (s.dest == src) && (s.dest != ZERO_REG);
  endfunction

endpackage

// File: rtl/operand_fetch_bypass_mux.sv
// ----------------------------------------------------------------------------
// bypass_mux
// Resolves one source operand.
//   src         : source register index
//   rdata       : register-file read data for src
//   es/ms/ws_fwd: bypass tuples from execute, memory and writeback stages
//   es_is_load  : the execute-stage instruction is a load
//   value       : resolved operand (ES > MS > WS > regfile, zero for r0)
//   es_load_hit : operand depends on a load still in ES (value not yet known)
// ----------------------------------------------------------------------------
module bypass_mux
  import operand_fetch_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] rdata,
  input  stage_fwd_t        es_fwd,
  input  stage_fwd_t        ms_fwd,
  input  stage_fwd_t        ws_fwd,
  input  logic              es_is_load,
  output logic [DATA_W-1:0] value,
  output logic              es_load_hit
);

  logic es_hit;
  logic ms_hit;
  logic ws_hit;

  assign es_hit = stage_hit(es_fwd, src);
  assign ms_hit = stage_hit(ms_fwd, src);
  assign ws_hit = stage_hit(ws_fwd, src);

  assign es_load_hit = es_hit && es_is_load;

  // WS is checked before rdata: the regfile write from WS only becomes
  // visible after the edge, so rdata is stale in the cycle WS matches.
  always_comb begin
    value = rdata;
    if (src == ZERO_REG) begin
      value = '0;
    end else if (es_hit) begin
      value = es_fwd.result;
    end else if (ms_hit) begin
      value = ms_fwd.result;
    end else if (ws_hit) begin
      value = ws_fwd.result;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// ----------------------------------------------------------------------------
// operand_fetch
// Decode/operand-fetch pipeline stage: latches one instruction from fetch,
// reads the register file, resolves both operands through the ES/MS/WS
// bypass network and hands the result to execute.
//   clk, resetn           : clock, synchronous active-low reset
//   fs_to_ds_valid/ds_allowin, fs_pc/src1/src2/dest/gr_we : upstream side
//   raddr1/2, rdata1/2    : combinational register-file read ports
//   es_*, ms_*, ws_*      : bypass sources
//   es_allowin/ds_to_es_valid, ds_pc/src1_val/src2_val/dest/gr_we : downstream
//   stall_cnt             : saturating count of load-use stall cycles
// ----------------------------------------------------------------------------
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              fs_to_ds_valid,
  output logic              ds_allowin,
  input  logic [DATA_W-1:0] fs_pc,
  input  logic [REG_AW-1:0] fs_src1,
  input  logic [REG_AW-1:0] fs_src2,
  input  logic [REG_AW-1:0] fs_dest,
  input  logic              fs_gr_we,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              es_valid,
  input  logic              es_gr_we,
  input  logic              es_is_load,
  input  logic [REG_AW-1:0] es_dest,
  input  logic [DATA_W-1:0] es_result,
  input  logic              ms_valid,
  input  logic              ms_gr_we,
  input  logic [REG_AW-1:0] ms_dest,
  input  logic [DATA_W-1:0] ms_result,
  input  logic              ws_valid,
  input  logic              ws_gr_we,
  input  logic [REG_AW-1:0] ws_dest,
  input  logic [DATA_W-1:0] ws_result,
  input  logic              es_allowin,
  output logic              ds_to_es_valid,
  output logic [DATA_W-1:0] ds_pc,
  output logic [DATA_W-1:0] ds_src1_val,
  output logic [DATA_W-1:0] ds_src2_val,
  output logic [REG_AW-1:0] ds_dest,
  output logic              ds_gr_we,
  output logic [DATA_W-1:0] stall_cnt
);

  logic              ds_valid_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [REG_AW-1:0] src1_reg;
  logic [REG_AW-1:0] src2_reg;
  logic [REG_AW-1:0] dest_reg;
  logic              gr_we_reg;
  logic [DATA_W-1:0] stall_cnt_reg;

  logic              ds_ready_go;
  logic              load_use;
  logic              accept;

  stage_fwd_t        es_fwd;
  stage_fwd_t        ms_fwd;
  stage_fwd_t        ws_fwd;

  logic [REG_AW-1:0] src_arr   [2];
  logic [DATA_W-1:0] rdata_arr [2];
  logic [DATA_W-1:0] value_arr [2];
  logic [1:0]        load_hit;

  assign es_fwd = '{valid: es_valid, gr_we: es_gr_we, dest: es_dest, result: es_result};
  assign ms_fwd = '{valid: ms_valid, gr_we: ms_gr_we, dest: ms_dest, result: ms_result};
  assign ws_fwd = '{valid: ws_valid, gr_we: ws_gr_we, dest: ws_dest, result: ws_result};

  assign src_arr[0]   = src1_reg;
  assign src_arr[1]   = src2_reg;
  assign rdata_arr[0] = rdata1;
  assign rdata_arr[1] = rdata2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      bypass_mux u_bypass_mux (
        .src         (src_arr[gi]),
        .rdata       (rdata_arr[gi]),
        .es_fwd      (es_fwd),
        .ms_fwd      (ms_fwd),
        .ws_fwd      (ws_fwd),
        .es_is_load  (es_is_load),
        .value       (value_arr[gi]),
        .es_load_hit (load_hit[gi])
      );
    end
  endgenerate

  // Load-use: the operand comes from a load whose data is not yet back.
  assign load_use       = ds_valid_reg && (|load_hit);
  assign ds_ready_go    = !load_use;
  assign ds_allowin     = !ds_valid_reg || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_reg && ds_ready_go;
  assign accept         = fs_to_ds_valid && ds_allowin;

  assign raddr1      = src1_reg;
  assign raddr2      = src2_reg;
  assign ds_src1_val = value_arr[0];
  assign ds_src2_val = value_arr[1];
  assign ds_pc       = pc_reg;
  assign ds_dest     = dest_reg;
  assign ds_gr_we    = gr_we_reg;
  assign stall_cnt   = stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ds_valid_reg <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid_reg <= fs_to_ds_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_reg    <= '0;
      src1_reg  <= '0;
      src2_reg  <= '0;
      dest_reg  <= '0;
      gr_we_reg <= 1'b0;
    end else if (accept) begin
      pc_reg    <= fs_pc;
      src1_reg  <= fs_src1;
      src2_reg  <= fs_src2;
      dest_reg  <= fs_dest;
      gr_we_reg <= fs_gr_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_reg <= '0;
    end else if (load_use && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic              clk = 1'b0;
  logic              resetn;
  logic              fs_to_ds_valid;
  logic              ds_allowin;
  logic [DATA_W-1:0] fs_pc;
  logic [REG_AW-1:0] fs_src1, fs_src2, fs_dest;
  logic              fs_gr_we;
  logic [REG_AW-1:0] raddr1, raddr2;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              es_valid, es_gr_we, es_is_load;
  logic [REG_AW-1:0] es_dest;
  logic [DATA_W-1:0] es_result;
  logic              ms_valid, ms_gr_we;
  logic [REG_AW-1:0] ms_dest;
  logic [DATA_W-1:0] ms_result;
  logic              ws_valid, ws_gr_we;
  logic [REG_AW-1:0] ws_dest;
  logic [DATA_W-1:0] ws_result;
  logic              es_allowin;
  logic              ds_to_es_valid;
  logic [DATA_W-1:0] ds_pc, ds_src1_val, ds_src2_val;
  logic [REG_AW-1:0] ds_dest;
  logic              ds_gr_we;
  logic [DATA_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // Register-file model: combinational read, write lands at the clock edge.
  logic [DATA_W-1:0] rf [32];
  assign rdata1 = rf[raddr1];
  assign rdata2 = rf[raddr2];
  always @(posedge clk) begin
    if (ws_valid && ws_gr_we && ws_dest != 0) rf[ws_dest] <= ws_result;
  end

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .resetn(resetn),
    .fs_to_ds_valid(fs_to_ds_valid), .ds_allowin(ds_allowin),
    .fs_pc(fs_pc), .fs_src1(fs_src1), .fs_src2(fs_src2),
    .fs_dest(fs_dest), .fs_gr_we(fs_gr_we),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .es_valid(es_valid), .es_gr_we(es_gr_we), .es_is_load(es_is_load),
    .es_dest(es_dest), .es_result(es_result),
    .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
    .ws_valid(ws_valid), .ws_gr_we(ws_gr_we), .ws_dest(ws_dest), .ws_result(ws_result),
    .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
    .ds_pc(ds_pc), .ds_src1_val(ds_src1_val), .ds_src2_val(ds_src2_val),
    .ds_dest(ds_dest), .ds_gr_we(ds_gr_we), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one clock, then let inputs settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_bypass();
    es_valid = 0; es_gr_we = 0; es_is_load = 0; es_dest = 0; es_result = 0;
    ms_valid = 0; ms_gr_we = 0; ms_dest = 0; ms_result = 0;
    ws_valid = 0; ws_gr_we = 0; ws_dest = 0; ws_result = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    fs_to_ds_valid = 1; fs_pc = pc; fs_src1 = s1; fs_src2 = s2; fs_dest = d; fs_gr_we = 1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1]    = 32'h1111ffff;
    rf[5]    = 32'h00000055;
    rf[5'h11] = 32'hdead0000;
    rf[5'h12] = 32'hbad00bad;
    resetn = 0; es_allowin = 1;
    fs_to_ds_valid = 0; fs_pc = 0; fs_src1 = 0; fs_src2 = 0; fs_dest = 0; fs_gr_we = 0;
    clear_bypass();
    tick(); tick();

    // Reset state
    check("rst_to_es_valid", {31'b0, ds_to_es_valid}, 32'h0);
    check("rst_allowin",     {31'b0, ds_allowin}, 32'h1);
    check("rst_stall_cnt",   stall_cnt, 32'h0);
    check("rst_pc",          ds_pc, 32'h0);
    check("rst_dest",        {27'b0, ds_dest}, 32'h0);
    resetn = 1;
    tick();

    // Regfile read, src2 = r2 holding 0
    offer(32'h100, 5'd1, 5'd2, 5'd3);
    #1 check("t1_allowin_before", {31'b0, ds_allowin}, 32'h1);
    tick();
    fs_to_ds_valid = 0;
    #1;
    check("t1_to_es_valid", {31'b0, ds_to_es_valid}, 32'h1);
    check("t1_src1_val",    ds_src1_val, 32'h1111ffff);
    check("t1_src2_val",    ds_src2_val, 32'h0);
    check("t1_pc",          ds_pc, 32'h100);
    check("t1_raddr1",      {27'b0, raddr1}, 32'h1);
    check("t1_dest",        {27'b0, ds_dest}, 32'h3);
    check("t1_gr_we",       {31'b0, ds_gr_we}, 32'h1);
    tick();
    check("t1_drained", {31'b0, ds_to_es_valid}, 32'h0);

    // ES beats MS; MS used once ES no longer matches
    offer(32'h200, 5'h10, 5'd0, 5'd4);
    tick();
    fs_to_ds_valid = 0;
    es_valid = 1; es_gr_we = 1; es_dest = 5'h10; es_result = 32'h0000ffff;
    ms_valid = 1; ms_gr_we = 1; ms_dest = 5'h10; ms_result = 32'h2222ffff;
    #1;
    check("t2_es_priority", ds_src1_val, 32'h0000ffff);
    es_valid = 0;
    #1;
    check("t2_ms_fallback", ds_src1_val, 32'h2222ffff);
    tick();
    clear_bypass();

    // WS writing the same register this cycle: WS value, not stale rdata
    offer(32'h300, 5'd0, 5'h11, 5'd6);
    tick();
    fs_to_ds_valid = 0;
    ws_valid = 1; ws_gr_we = 1; ws_dest = 5'h11; ws_result = 32'h3333ffff;
    #1;
    check("t3_ws_bypass", ds_src2_val, 32'h3333ffff);
    tick();
    clear_bypass();

    // Load-use stall for one cycle, then MS forwards the load data
    offer(32'h400, 5'h12, 5'd0, 5'd7);
    tick();
    fs_to_ds_valid = 0;
    es_valid = 1; es_gr_we = 1; es_is_load = 1; es_dest = 5'h12; es_result = 32'hbad0bad0;
    #1;
    check("t4_stall_allowin",   {31'b0, ds_allowin}, 32'h0);
    check("t4_stall_to_es",     {31'b0, ds_to_es_valid}, 32'h0);
    check("t4_stall_cnt_before", stall_cnt, 32'h0);
    tick();
    check("t4_stall_cnt_after", stall_cnt, 32'h1);
    clear_bypass();
    ms_valid = 1; ms_gr_we = 1; ms_dest = 5'h12; ms_result = 32'h4444ffff;
    #1;
    check("t4_release_to_es",  {31'b0, ds_to_es_valid}, 32'h1);
    check("t4_release_allowin", {31'b0, ds_allowin}, 32'h1);
    check("t4_ms_value",        ds_src1_val, 32'h4444ffff);
    tick();
    clear_bypass();
    check("t4_stall_cnt_hold", stall_cnt, 32'h1);

    // r0 ignores a matching ES (even a load): value 0, no stall
    offer(32'h500, 5'd0, 5'd0, 5'd8);
    tick();
    fs_to_ds_valid = 0;
    es_valid = 1; es_gr_we = 1; es_is_load = 1; es_dest = 5'd0; es_result = 32'hffffffff;
    #1;
    check("t5_zero_val",   ds_src1_val, 32'h0);
    check("t5_no_stall",   {31'b0, ds_to_es_valid}, 32'h1);
    check("t5_stall_cnt",  stall_cnt, 32'h1);
    tick();
    clear_bypass();

    // Downstream back-pressure for 3 cycles, operands recomputed, then reset
    es_allowin = 0;
    offer(32'h600, 5'd5, 5'd0, 5'd9);
    tick();
    fs_to_ds_valid = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        ws_valid = 1; ws_gr_we = 1; ws_dest = 5'd5; ws_result = 32'h5555aaaa;
      end
      #1;
      check("t6_hold_allowin", {31'b0, ds_allowin}, 32'h0);
      check("t6_hold_pc",      ds_pc, 32'h600);
      check("t6_hold_src1",    ds_src1_val, (c == 2) ? 32'h5555aaaa : 32'h00000055);
      tick();
    end
    clear_bypass();
    resetn = 0;
    tick();
    check("t6_rst_to_es",    {31'b0, ds_to_es_valid}, 32'h0);
    check("t6_rst_allowin",  {31'b0, ds_allowin}, 32'h1);
    check("t6_rst_stall",    stall_cnt, 32'h0);
    check("t6_rst_pc",       ds_pc, 32'h0);
    resetn = 1; es_allowin = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t6_post_rst_idle", {31'b0, ds_to_es_valid}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
